dac_8734_sequencer: RTL
=======================

Name: dac_8734_sequencer

Overview:
- Sits directly upstream of the DAC_8734 serial engine and owns its control registers.
- Holds host-written target codes for 20 channels (5 devices × 4 channels) and drives the active codes toward those targets, slew-limited per update.
- Runs the level handshakes for output updates and one-shot SET (raw 24-bit) transfers.

Parameters:
- MAX_STEP, 16'd0, maximum code change per channel per update; 0 = jump straight to target.
- UPDATE_INTERVAL, 16'd1000, DAC_REF_CLK cycles of holdoff between ramp updates.

Ports:
- DAC_REF_CLK  in  1  system clock; same clock as the DAC engine.
- nRESET  in  1  asynchronous, active-low reset.
- WR_EN  in  1  host write strobe for a target code.
- WR_ADDR  in  5  channel index = dac*4 + ch, valid range 0..19.
- WR_DATA  in  16  target code.
- SET_REQ  in  1  single-cycle request for a raw SET transfer.
- SET_SEL  in  5  one-hot device select.
- SET_WORD  in  24  raw word to transfer.
- DAC_READY  in  1  from the engine.
- DAC_OUTPUT_DONE  in  1  from the engine.
- DAC_SET_DONE  in  1  from the engine.
- REG_DAC_CONTROL  out  16  bit0 = output request; bits 15:1 are always 0.
- DAC_CODES  out  320  active codes; channel n occupies [16n+15:16n]. Top level splits this into REG_DACx_OUTPUTy.
- REG_DAC_SETCONTROL  out  16  bits 4:0 = device select; bits 15:5 are always 0.
- REG_DAC_SETBUFFER0  out  16  SET_WORD[15:0].
- REG_DAC_SETBUFFER1  out  16  {8'd0, SET_WORD[23:16]}.
- BUSY  out  1  high whenever the FSM is not in S_IDLE.
- RAMP_ACTIVE  out  1  some active code differs from its target.
- SET_ACK  out  1  one-cycle pulse when a SET transfer completes.

Behaviour:
- Reset (asynchronous, nRESET=0):
  - All outputs are 0.
  - Target and active codes are 0.
  - PENDING=0 and the SET latch is empty.
  - FSM goes to S_IDLE.
  - Assertion mid-transfer drops CONTROL and SETCONTROL immediately.
- Host writes:
  - Accepted every cycle.
  - WR_ADDR ≥ 20 is ignored.
  - A valid write updates the target and sets PENDING.
- SET_REQ:
  - Latched into a one-deep buffer (select + word).
  - A SET_REQ arriving while the buffer is full is dropped.
  - SET_SEL == 0 is dropped.
- S_IDLE:
  - If the SET buffer is full, go to S_SET_REQ. SET takes priority when a SET and PENDING/ramp are both outstanding.
  - Else if PENDING or RAMP_ACTIVE, and the holdoff timer is 0, go to S_CALC.
- S_CALC:
  - Clears PENDING on entry.
  - Walks channels 0..19, one per cycle, over 20 cycles.
  - Per channel: if MAX_STEP==0 or |tgt-act| ≤ MAX_STEP, then act = tgt; else act = act ± MAX_STEP.
  - Arithmetic is unsigned 16-bit; the difference is computed at 17 bits, so there is no wrap.
  - A write landing during CALC re-sets PENDING. A channel already visited picks up the new target on the next pass.
  - After channel 19, go to S_OUT_REQ.
- S_OUT_REQ:
  - Wait for DAC_READY=1.
  - Then set CONTROL[0]=1 and go to S_OUT_WAIT.
  - DAC_CODES is frozen from CALC exit until S_OUT_REL exits.
- S_OUT_WAIT:
  - Hold CONTROL[0]=1 until DAC_OUTPUT_DONE=1.
  - Then clear CONTROL[0] and go to S_OUT_REL.
- S_OUT_REL:
  - Wait for DAC_OUTPUT_DONE=0.
  - Load the holdoff timer with UPDATE_INTERVAL, then go to S_IDLE.
  - The timer only gates ramp continuation; host-write PENDING bypasses it.
- S_SET_REQ:
  - Wait for DAC_READY=1.
  - Drive SETBUFFER0/1 and SETCONTROL from the latch in the same cycle, then go to S_SET_WAIT.
- S_SET_WAIT:
  - Wait for DAC_SET_DONE=1.
  - Then clear SETCONTROL to 0, pulse SET_ACK, empty the latch, and go to S_SET_REL.
- S_SET_REL:
  - Wait for DAC_SET_DONE=0, then go to S_IDLE.
- Exclusivity: CONTROL[0] and SETCONTROL[4:0] are never nonzero in the same cycle.
- RAMP_ACTIVE is registered. It is recomputed as the OR of per-channel mismatch flags, which are updated in CALC and on writes.

Decomposition:
- Shared package dac_8734_pkg:
  - NUM_DAC=5, CH_PER_DAC=4, NUM_CH=20
  - code width 16, SET word width 24
  - FSM state encodings
- One sub-module is natural: dac_slew_step (combinational). Inputs are tgt, act, MAX_STEP; outputs are next act and a mismatch flag. It is instantiated once and shared across CALC cycles.

Test Plan:
- MAX_STEP=0; write ch5=0x8000; engine model returns DONE → one transfer; DAC_CODES[95:80]=0x8000; CONTROL[0] high only until DONE; RAMP_ACTIVE=0.
- MAX_STEP=0x1000, UPDATE_INTERVAL=100; write ch0=0x3800 → three updates with codes 0x1000, 0x2000, 0x3000, then 0x3800; updates ≥100 cycles apart.
- Down-ramp ch19 from 0xFFFF to 0x0005 with MAX_STEP=0x4000 → 0xBFFF, 0x7FFF, 0x3FFF, 0x0005; no underflow.
- SET_REQ sel=5'b00100, word=0xA5_1234 while PENDING → SET runs first; BUFFER0=0x1234, BUFFER1=0x00A5; SET_ACK pulses once; the output transfer follows.
- WR_ADDR=20 or 31 → no target change and no transfer. SET_REQ while the latch is full → dropped, one SET_ACK only.
- nRESET pulsed low during S_OUT_WAIT → CONTROL, DAC_CODES and BUSY go to 0 asynchronously; after release the FSM sits in S_IDLE with no transfer.

Source files
------------

// File: rtl/dac_8734_sequencer_pkg.sv
// Shared constants, types and FSM encoding for the DAC_8734 sequencer.
package dac_8734_pkg;
  localparam int NUM_DAC    = 5;
  localparam int CH_PER_DAC = 4;
  localparam int NUM_CH     = NUM_DAC * CH_PER_DAC;
  localparam int CODE_W     = 16;
  localparam int SET_W      = 24;
  localparam int CH_IDX_W   = 5;
  localparam int SEL_W      = NUM_DAC;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_OUT_REQ,
    S_OUT_WAIT,
    S_OUT_REL,
    S_SET_REQ,
    S_SET_WAIT,
    S_SET_REL
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SET_W-1:0] word;
  } set_req_t;

  function automatic logic addr_ok(input logic [CH_IDX_W-1:0] a);
    return a < CH_IDX_W'(NUM_CH);
  endfunction
endpackage

// File: rtl/dac_8734_sequencer_if.sv
// Host + engine bus of the sequencer; master = sequencer, slave = host/engine side.
interface dac_8734_sequencer_if;
  import dac_8734_pkg::*;

  logic                     WR_EN;
  logic [CH_IDX_W-1:0]      WR_ADDR;
  code_t                    WR_DATA;
  logic                     SET_REQ;
  logic [SEL_W-1:0]         SET_SEL;
  logic [SET_W-1:0]         SET_WORD;
  logic                     DAC_READY;
  logic                     DAC_OUTPUT_DONE;
  logic                     DAC_SET_DONE;
  logic [15:0]              REG_DAC_CONTROL;
  logic [NUM_CH*CODE_W-1:0] DAC_CODES;
  logic [15:0]              REG_DAC_SETCONTROL;
  logic [15:0]              REG_DAC_SETBUFFER0;
  logic [15:0]              REG_DAC_SETBUFFER1;
  logic                     BUSY;
  logic                     RAMP_ACTIVE;
  logic                     SET_ACK;

  modport master (
    input  WR_EN, WR_ADDR, WR_DATA, SET_REQ, SET_SEL, SET_WORD,
           DAC_READY, DAC_OUTPUT_DONE, DAC_SET_DONE,
    output REG_DAC_CONTROL, DAC_CODES, REG_DAC_SETCONTROL,
           REG_DAC_SETBUFFER0, REG_DAC_SETBUFFER1, BUSY, RAMP_ACTIVE, SET_ACK
  );

  modport slave (
    output WR_EN, WR_ADDR, WR_DATA, SET_REQ, SET_SEL, SET_WORD,
           DAC_READY, DAC_OUTPUT_DONE, DAC_SET_DONE,
    input  REG_DAC_CONTROL, DAC_CODES, REG_DAC_SETCONTROL,
           REG_DAC_SETBUFFER0, REG_DAC_SETBUFFER1, BUSY, RAMP_ACTIVE, SET_ACK
  );
endinterface

// File: rtl/dac_8734_sequencer_slew_step.sv
// One slew-limited step of a channel toward its target; shared across CALC cycles.
module dac_slew_step
  import dac_8734_pkg::*;
(
  input  code_t tgt_i,
  input  code_t act_i,
  input  code_t step_i,
  output code_t nxt_o,
  output logic  mis_o
);
  logic [CODE_W:0] diff;
  logic [CODE_W:0] mag;
  logic            up;

  always_comb begin
    // 17-bit difference keeps the sign, so neither direction can wrap
    diff = {1'b0, tgt_i} - {1'b0, act_i};
    up   = ~diff[CODE_W];
    mag  = up ? diff : (~diff + 1'b1);
    if (step_i == '0 || mag <= {1'b0, step_i}) nxt_o = tgt_i;
    else if (up)                               nxt_o = act_i + step_i;
    else                                       nxt_o = act_i - step_i;
    mis_o = (nxt_o != tgt_i);
  end
endmodule

// File: rtl/dac_8734_sequencer.sv
// Target/active code store, slew ramping and DAC_8734 engine handshakes.
module dac_8734_sequencer
  import dac_8734_pkg::*;
#(
  parameter logic [15:0] MAX_STEP        = 16'd0,
  parameter logic [15:0] UPDATE_INTERVAL = 16'd1000
) (
  input  logic                  DAC_REF_CLK,
  input  logic                  nRESET,
  dac_8734_sequencer_if.master  bus
);
  code_t [NUM_CH-1:0] tgt_q, tgt_d, act_q, act_d;
  logic  [NUM_CH-1:0] mis_q, mis_d;
  logic               ramp_q, pend_q;
  state_t             state_q;
  logic [CH_IDX_W-1:0] ch_q;
  logic [15:0]        hold_q;
  logic               set_full_q;
  set_req_t           set_q;
  logic               ctl_q, ack_q;
  logic [SEL_W-1:0]   setctl_q;
  code_t              buf0_q, buf1_q;
  code_t              step_nxt;
  logic               step_mis;
  logic               wr_ok, set_ok, calc_go;

  assign wr_ok   = bus.WR_EN && addr_ok(bus.WR_ADDR);
  assign set_ok  = bus.SET_REQ && !set_full_q && (bus.SET_SEL != '0);
  // host writes bypass the holdoff; only ramp continuation waits for it
  assign calc_go = !set_full_q && (pend_q || (ramp_q && hold_q == '0));

  dac_slew_step u_step (
    .tgt_i  (tgt_q[ch_q]),
    .act_i  (act_q[ch_q]),
    .step_i (MAX_STEP),
    .nxt_o  (step_nxt),
    .mis_o  (step_mis)
  );

  always_comb begin
    tgt_d = tgt_q;
    act_d = act_q;
    mis_d = mis_q;
    if (state_q == S_CALC) begin
      act_d[ch_q] = step_nxt;
      mis_d[ch_q] = step_mis;
    end
    if (wr_ok) begin
      tgt_d[bus.WR_ADDR] = bus.WR_DATA;
      mis_d[bus.WR_ADDR] = (bus.WR_DATA != act_d[bus.WR_ADDR]);
    end
  end

  always_ff @(posedge DAC_REF_CLK or negedge nRESET) begin
    if (!nRESET) begin
      tgt_q  <= '0;
      act_q  <= '0;
      mis_q  <= '0;
      ramp_q <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      act_q  <= act_d;
      mis_q  <= mis_d;
      ramp_q <= |mis_d;
    end
  end

  always_ff @(posedge DAC_REF_CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      pend_q     <= 1'b0;
      hold_q     <= '0;
      set_full_q <= 1'b0;
      set_q      <= '0;
      ctl_q      <= 1'b0;
      setctl_q   <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (hold_q != '0) hold_q <= hold_q - 1'b1;
      if (set_ok) begin
        set_full_q <= 1'b1;
        set_q      <= '{sel: bus.SET_SEL, word: bus.SET_WORD};
      end
      case (state_q)
        S_IDLE: begin
          if (set_full_q) state_q <= S_SET_REQ;
          else if (calc_go) begin
            state_q <= S_CALC;
            ch_q    <= '0;
            pend_q  <= 1'b0;
          end
        end
        S_CALC: begin
          if (ch_q == CH_IDX_W'(NUM_CH-1)) state_q <= S_OUT_REQ;
          else                             ch_q    <= ch_q + 1'b1;
        end
        S_OUT_REQ: if (bus.DAC_READY) begin
          ctl_q   <= 1'b1;
          state_q <= S_OUT_WAIT;
        end
        S_OUT_WAIT: if (bus.DAC_OUTPUT_DONE) begin
          ctl_q   <= 1'b0;
          state_q <= S_OUT_REL;
        end
        S_OUT_REL: if (!bus.DAC_OUTPUT_DONE) begin
          hold_q  <= UPDATE_INTERVAL;
          state_q <= S_IDLE;
        end
        S_SET_REQ: if (bus.DAC_READY) begin
          setctl_q <= set_q.sel;
          buf0_q   <= set_q.word[15:0];
          buf1_q   <= {8'd0, set_q.word[23:16]};
          state_q  <= S_SET_WAIT;
        end
        S_SET_WAIT: if (bus.DAC_SET_DONE) begin
          setctl_q   <= '0;
          ack_q      <= 1'b1;
          set_full_q <= 1'b0;
          state_q    <= S_SET_REL;
        end
        S_SET_REL: if (!bus.DAC_SET_DONE) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // a write landing mid-CALC re-arms another pass
      if (wr_ok) pend_q <= 1'b1;
    end
  end

  assign bus.REG_DAC_CONTROL    = {15'd0, ctl_q};
  assign bus.DAC_CODES          = act_q;
  assign bus.REG_DAC_SETCONTROL = {{(16-SEL_W){1'b0}}, setctl_q};
  assign bus.REG_DAC_SETBUFFER0 = buf0_q;
  assign bus.REG_DAC_SETBUFFER1 = buf1_q;
  assign bus.BUSY               = (state_q != S_IDLE);
  assign bus.RAMP_ACTIVE        = ramp_q;
  assign bus.SET_ACK            = ack_q;
endmodule
